// File: rtl/fa_exhaustive_checker_pkg.sv
// Shared definitions for the full-adder exhaustive checker: FSM encoding and
// the {a, b, c_in} vector width used by both the RTL and the bench.
package fa_exhaustive_checker_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic int vec_width(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/fa_exhaustive_checker_golden.sv
// Golden reference adder: {c_out, sum} = a + b + c_in, unsigned, WIDTH+1 bits.
module fa_golden_model
  import fa_exhaustive_checker_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};

endmodule

// File: rtl/fa_exhaustive_checker.sv
// Walks every {a, b, c_in} vector into an external adder, holds each for DWELL
// cycles, and checks the adder result on the last cycle against a golden model.
module fa_exhaustive_checker
  import fa_exhaustive_checker_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DWELL = 10,
  parameter int ERR_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic [WIDTH-1:0]          a,
  output logic [WIDTH-1:0]          b,
  output logic                      c_in,
  input  logic [WIDTH-1:0]          dut_sum,
  input  logic                      dut_c_out,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ERR_W-1:0]          err_count,
  output logic                      first_err_valid,
  output logic [2*WIDTH:0]          first_err_vec
);

  localparam int VW  = vec_width(WIDTH);
  localparam int DCW = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL - 1);

  logic [1:0]       state_r;
  logic [VW-1:0]    vec_r;
  logic [DCW-1:0]   dwell_r;
  logic [ERR_W-1:0] err_r;
  logic [ERR_W-1:0] err_nxt_s;
  logic             first_valid_r;
  logic [VW-1:0]    first_vec_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [WIDTH-1:0] gold_sum_s;
  logic             gold_c_out_s;
  logic             compare_s;
  logic             mismatch_s;

  // The vector register itself is the stimulus, so a/b/c_in are glitch-free.
  assign a               = vec_r[VW-1 -: WIDTH];
  assign b               = vec_r[1 +: WIDTH];
  assign c_in            = vec_r[0];
  assign busy            = busy_r;
  assign done            = done_r;
  assign pass            = pass_r;
  assign err_count       = err_r;
  assign first_err_valid = first_valid_r;
  assign first_err_vec   = first_vec_r;

  fa_golden_model #(.WIDTH(WIDTH)) u_golden (
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .sum   (gold_sum_s),
    .c_out (gold_c_out_s)
  );

  // Compare strobe, mismatch detect and saturating next error count.
  always_comb begin
    compare_s  = (state_r == ST_APPLY) && (dwell_r == DWELL_LAST);
    mismatch_s = compare_s && ({dut_c_out, dut_sum} != {gold_c_out_s, gold_sum_s});
    if (mismatch_s && !(&err_r)) begin
      err_nxt_s = err_r + ERR_W'(1);
    end else begin
      err_nxt_s = err_r;
    end
  end

  // Run sequencer: vector stepping, dwell timing and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      vec_r         <= {VW{1'b0}};
      dwell_r       <= {DCW{1'b0}};
      err_r         <= {ERR_W{1'b0}};
      first_valid_r <= 1'b0;
      first_vec_r   <= {VW{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r       <= ST_APPLY;
            vec_r         <= {VW{1'b0}};
            dwell_r       <= {DCW{1'b0}};
            err_r         <= {ERR_W{1'b0}};
            first_valid_r <= 1'b0;
            first_vec_r   <= {VW{1'b0}};
            busy_r        <= 1'b1;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
          end
        end
        ST_APPLY: begin
          err_r <= err_nxt_s;
          if (mismatch_s && !first_valid_r) begin
            first_valid_r <= 1'b1;
            first_vec_r   <= vec_r;
          end
          if (compare_s) begin
            if (&vec_r) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              pass_r  <= (err_nxt_s == {ERR_W{1'b0}});
            end else begin
              vec_r   <= vec_r + VW'(1);
              dwell_r <= {DCW{1'b0}};
            end
          end else begin
            dwell_r <= dwell_r + DCW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          pass_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fa_exhaustive_checker.sv
// Bench: three checker instances driving bench-side adders with selectable
// faults, random fault masks and a settling glitch, scored against a vector-loop model.
module tb_fa_exhaustive_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_v[3];
  logic start_v[3];

  // instance 0: WIDTH=1 DWELL=10 ERR_W=16
  logic a0, b0, ci0, sum0, co0, busy0, done0, pass0, fev0;
  logic [15:0] err0;
  logic [2:0]  fvec0;
  // instance 1: WIDTH=1 DWELL=10 ERR_W=2
  logic a1, b1, ci1, sum1, co1, busy1, done1, pass1, fev1;
  logic [1:0] err1;
  logic [2:0] fvec1;
  // instance 2: WIDTH=2 DWELL=3 ERR_W=16
  logic [1:0] a2, b2, sum2;
  logic ci2, co2, busy2, done2, pass2, fev2;
  logic [15:0] err2;
  logic [4:0]  fvec2;

  int w_of[3]  = '{1, 1, 2};
  int dw_of[3] = '{10, 10, 3};
  int ew_of[3] = '{16, 2, 16};

  int mode[3];
  bit glitch[3];
  int mask[3][32];
  int age[3];
  int prev_vec[3];
  bit prev_busy[3];

  int st_vec[3], st_err[3], st_fvec[3];
  bit st_busy[3], st_done[3], st_pass[3], st_fev[3];

  int n_cmp = 0;
  int n_mis = 0;

  fa_exhaustive_checker #(.WIDTH(1), .DWELL(10), .ERR_W(16)) u_dut0 (
    .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .a(a0), .b(b0), .c_in(ci0),
    .dut_sum(sum0), .dut_c_out(co0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_err_valid(fev0), .first_err_vec(fvec0));

  fa_exhaustive_checker #(.WIDTH(1), .DWELL(10), .ERR_W(2)) u_dut1 (
    .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .a(a1), .b(b1), .c_in(ci1),
    .dut_sum(sum1), .dut_c_out(co1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_valid(fev1), .first_err_vec(fvec1));

  fa_exhaustive_checker #(.WIDTH(2), .DWELL(3), .ERR_W(16)) u_dut2 (
    .clk(clk), .reset(reset_v[2]), .start(start_v[2]), .a(a2), .b(b2), .c_in(ci2),
    .dut_sum(sum2), .dut_c_out(co2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_err_valid(fev2), .first_err_vec(fvec2));

  // Adder under test behaviour: true sum with an optional injected fault.
  function automatic int faulty(input int md, input int msk, input int av, input int bv,
                                input int cv, input int w);
    int g;
    g = av + bv + cv;
    case (md)
      1:       return g & (1 << w);
      2:       return g ^ (1 << w);
      3:       return g ^ msk;
      default: return g;
    endcase
  endfunction

  // Output is garbage until DWELL-2 cycles after the vector changes.
  function automatic int adder_out(input int md, input int msk, input bit gl, input int ag,
                                   input int dw, input int av, input int bv, input int cv,
                                   input int w);
    int r;
    r = faulty(md, msk, av, bv, cv, w);
    if (gl && ag < dw - 2) r = r ^ ((1 << (w + 1)) - 1);
    return r;
  endfunction

  int r0, r1, r2;
  always_comb begin
    r0 = adder_out(mode[0], mask[0][int'({a0, b0, ci0})], glitch[0], age[0], 10,
                   int'(a0), int'(b0), int'(ci0), 1);
    r1 = adder_out(mode[1], mask[1][int'({a1, b1, ci1})], glitch[1], age[1], 10,
                   int'(a1), int'(b1), int'(ci1), 1);
    r2 = adder_out(mode[2], mask[2][int'({a2, b2, ci2})], glitch[2], age[2], 3,
                   int'(a2), int'(b2), int'(ci2), 2);
  end
  assign sum0 = r0[0];
  assign co0  = r0[1];
  assign sum1 = r1[0];
  assign co1  = r1[1];
  assign sum2 = r2[1:0];
  assign co2  = r2[2];

  always_comb begin
    st_vec[0] = int'({a0, b0, ci0});  st_vec[1] = int'({a1, b1, ci1});  st_vec[2] = int'({a2, b2, ci2});
    st_err[0] = int'(err0);  st_err[1] = int'(err1);  st_err[2] = int'(err2);
    st_fvec[0] = int'(fvec0); st_fvec[1] = int'(fvec1); st_fvec[2] = int'(fvec2);
    st_busy[0] = busy0; st_busy[1] = busy1; st_busy[2] = busy2;
    st_done[0] = done0; st_done[1] = done1; st_done[2] = done2;
    st_pass[0] = pass0; st_pass[1] = pass1; st_pass[2] = pass2;
    st_fev[0]  = fev0;  st_fev[1]  = fev1;  st_fev[2]  = fev2;
  end

  // Cycles elapsed since each instance last presented a new vector.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (st_vec[i] != prev_vec[i] || (st_busy[i] && !prev_busy[i])) age[i] = 0;
      else if (age[i] < 1000) age[i] = age[i] + 1;
      prev_vec[i]  = st_vec[i];
      prev_busy[i] = st_busy[i];
    end
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: walk the whole vector space and score the adder against plain a+b+c.
  task automatic model(input int i, output int e_err, output int e_fv, output int e_fvec);
    int w, n, sat, av, bv, cv;
    w = w_of[i];
    n = 1 << (2 * w + 1);
    sat = (1 << ew_of[i]) - 1;
    e_err = 0; e_fv = 0; e_fvec = 0;
    for (int v = 0; v < n; v++) begin
      av = v >> (w + 1);
      bv = (v >> 1) & ((1 << w) - 1);
      cv = v & 1;
      if (faulty(mode[i], mask[i][v], av, bv, cv, w) != av + bv + cv) begin
        if (e_err < sat) e_err++;
        if (e_fv == 0) begin e_fv = 1; e_fvec = v; end
      end
    end
  endtask

  task automatic run_one(input int i, input string tag);
    int bc, ee, efv, efvec, n;
    model(i, ee, efv, efvec);
    n = 1 << (2 * w_of[i] + 1);
    start_v[i] = 1'b1;
    @(posedge clk); #1;
    start_v[i] = 1'b0;
    bc = 0;
    while (st_busy[i] && bc < n * dw_of[i] + 50) begin
      bc++;
      @(posedge clk); #1;
    end
    check_eq({tag, "_busy_cycles"}, bc, n * dw_of[i]);
    check_eq({tag, "_done"}, st_done[i], 1);
    check_eq({tag, "_pass"}, st_pass[i], (ee == 0) ? 1 : 0);
    check_eq({tag, "_err_count"}, st_err[i], ee);
    check_eq({tag, "_first_valid"}, st_fev[i], efv);
    if (efv != 0) check_eq({tag, "_first_vec"}, st_fvec[i], efvec);
    check_eq({tag, "_last_vec_held"}, st_vec[i], n - 1);
  endtask

  task automatic randomize_mask(input int i);
    int w;
    w = w_of[i];
    for (int v = 0; v < 32; v++)
      mask[i][v] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, (1 << (w + 1)) - 1)) : 0;
  endtask

  initial begin
    int bc;
    for (int i = 0; i < 3; i++) begin
      reset_v[i] = 1'b1; start_v[i] = 1'b0; mode[i] = 0; glitch[i] = 1'b0;
      age[i] = 1000; prev_vec[i] = 0; prev_busy[i] = 1'b0;
      for (int v = 0; v < 32; v++) mask[i][v] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy0, 0);
    check_eq("rst_done", done0, 0);
    check_eq("rst_pass", pass0, 0);
    check_eq("rst_err", err0, 0);
    check_eq("rst_fev", fev0, 0);
    check_eq("rst_fvec", fvec0, 0);
    check_eq("rst_vec", st_vec[0], 0);
    for (int i = 0; i < 3; i++) reset_v[i] = 1'b0;
    @(posedge clk); #1;

    mode[0] = 0; glitch[0] = 1'b1;
    run_one(0, "clean");
    mode[0] = 1;
    run_one(0, "sum_sa0");
    check_eq("sum_sa0_err_4", err0, 4);
    check_eq("sum_sa0_fvec_001", fvec0, 1);
    mode[0] = 2;
    run_one(0, "cout_inv");
    check_eq("cout_inv_err_8", err0, 8);
    check_eq("cout_inv_fvec_000", fvec0, 0);

    for (int k = 0; k < 4; k++) begin
      mode[0] = 3; glitch[0] = bit'($urandom_range(0, 1));
      randomize_mask(0);
      run_one(0, "rand_w1");
    end

    mode[1] = 2; glitch[1] = 1'b1;
    run_one(1, "errw2_sat");
    check_eq("errw2_sat_3", err1, 3);

    mode[2] = 0; glitch[2] = 1'b1;
    run_one(2, "w2_clean");
    for (int k = 0; k < 3; k++) begin
      mode[2] = 3;
      randomize_mask(2);
      run_one(2, "rand_w2");
    end

    // Reset 35 cycles into a faulty run, then a clean run.
    mode[0] = 2; glitch[0] = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (34) @(posedge clk);
    #1;
    check_eq("mid_err_before_reset", err0, 3);
    reset_v[0] = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_busy", busy0, 0);
    check_eq("mid_rst_done", done0, 0);
    check_eq("mid_rst_vec", st_vec[0], 0);
    check_eq("mid_rst_err", err0, 0);
    check_eq("mid_rst_fev", fev0, 0);
    reset_v[0] = 1'b0;
    mode[0] = 0; glitch[0] = 1'b1;
    run_one(0, "after_reset");

    // start held high for a whole run.
    mode[0] = 2;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    bc = 0;
    while (busy0 && bc < 200) begin
      bc++;
      @(posedge clk); #1;
    end
    check_eq("held_busy_cycles", bc, 80);
    check_eq("held_done", done0, 1);
    check_eq("held_err", err0, 8);
    @(posedge clk); #1;
    check_eq("held_restart_done", done0, 0);
    check_eq("held_restart_busy", busy0, 1);
    check_eq("held_restart_vec", st_vec[0], 0);
    check_eq("held_restart_err", err0, 0);
    check_eq("held_restart_fev", fev0, 0);
    start_v[0] = 1'b0;
    bc = 0;
    while (!done0 && bc < 200) begin
      bc++;
      @(posedge clk); #1;
    end
    check_eq("held_second_done", done0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
